// File: rtl/hub75_rx_if.sv
// Capture-write channel from the HUB75 receiver to the frame-store sink.
// A write transfers on every rising clk edge where wr_valid and wr_ready are both high;
// while wr_valid is high and wr_ready is low, wr_addr and wr_data hold steady.
interface hub75_rx_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [11:0] wr_addr;
  logic [3:0]  wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/hub75_rx.sv
// HUB75 panel receiver: oversamples the shift bus, fills a ping-pong line buffer
// and dumps each latched row as {half,row,col} writes over a valid/ready channel.
module hub75_rx #(
  parameter int COLUMNS = 64,
  parameter int ROWS    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pclk,
  input  logic              latch,
  input  logic [4:0]        row_addr,
  input  logic [3:0]        din_a,
  input  logic [3:0]        din_b,
  hub75_rx_if.master        wr,
  output logic              frame_done,
  output logic              line_err,
  output logic              overrun_err,
  input  logic              err_clr,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DUMP = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int         CW     = $clog2(COLUMNS);
  localparam logic [6:0] COLS   = 7'(COLUMNS);
  localparam logic [6:0] SAT    = 7'(COLUMNS + 1);
  localparam logic [6:0] LAST   = 7'(2 * COLUMNS - 1);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

  // Bundle layout: {pclk, latch, row_addr, din_a, din_b}, all delayed identically.
  logic [14:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic        pclk_prev_q, pclk_prev_d, latch_prev_q, latch_prev_d;
  logic [1:0]  state_q, state_d;
  logic [6:0]  idx_q, idx_d;
  logic [6:0]  col_cnt_q, col_cnt_d;
  logic [4:0]  row_q, row_d;
  logic        fill_bank_q, fill_bank_d;
  logic        line_err_q, line_err_d;
  logic        overrun_err_q, overrun_err_d;

  logic [3:0]  buf_a [0:1][0:COLUMNS-1];
  logic [3:0]  buf_b [0:1][0:COLUMNS-1];

  logic        pclk_s, latch_s, pclk_rise, latch_rise, fill_we;
  logic        line_set, overrun_set, top_half, rd_bank;
  logic [4:0]  row_s;
  logic [3:0]  din_a_s, din_b_s;
  logic [6:0]  col_idx;

  assign pclk_s     = sync2_q[14];
  assign latch_s    = sync2_q[13];
  assign row_s      = sync2_q[12:8];
  assign din_a_s    = sync2_q[7:4];
  assign din_b_s    = sync2_q[3:0];
  assign pclk_rise  = pclk_s & ~pclk_prev_q;
  assign latch_rise = latch_s & ~latch_prev_q;
  assign fill_we    = pclk_rise && (col_cnt_q < COLS);

  always_comb begin
    sync1_d       = {pclk, latch, row_addr, din_a, din_b};
    sync2_d       = sync1_q;
    pclk_prev_d   = pclk_s;
    latch_prev_d  = latch_s;
    state_d       = state_q;
    idx_d         = idx_q;
    col_cnt_d     = col_cnt_q;
    row_d         = row_q;
    fill_bank_d   = fill_bank_q;
    line_set      = 1'b0;
    overrun_set   = 1'b0;

    if (pclk_rise && (col_cnt_q != SAT)) col_cnt_d = col_cnt_q + 7'd1;

    case (state_q)
      S_IDLE: begin
        if (latch_rise) begin
          row_d       = row_s;
          fill_bank_d = ~fill_bank_q;
          idx_d       = 7'd0;
          state_d     = S_DUMP;
        end
      end
      S_DUMP: begin
        if (wr.wr_ready) begin
          if (idx_q == LAST) state_d = S_DONE;
          else               idx_d   = idx_q + 7'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Any latch restarts the column count; only one seen in IDLE starts a dump.
    if (latch_rise) begin
      line_set  = (col_cnt_q != COLS);
      col_cnt_d = 7'd0;
      if (state_q != S_IDLE) overrun_set = 1'b1;
    end

    line_err_d    = line_set    | (line_err_q    & ~err_clr);
    overrun_err_d = overrun_set | (overrun_err_q & ~err_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      pclk_prev_q   <= 1'b0;
      latch_prev_q  <= 1'b0;
      state_q       <= S_IDLE;
      idx_q         <= 7'd0;
      col_cnt_q     <= 7'd0;
      row_q         <= 5'd0;
      fill_bank_q   <= 1'b0;
      line_err_q    <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      pclk_prev_q   <= pclk_prev_d;
      latch_prev_q  <= latch_prev_d;
      state_q       <= state_d;
      idx_q         <= idx_d;
      col_cnt_q     <= col_cnt_d;
      row_q         <= row_d;
      fill_bank_q   <= fill_bank_d;
      line_err_q    <= line_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  // Line buffer is plain storage; its contents survive reset.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      buf_a[fill_bank_q][col_cnt_q[CW-1:0]] <= din_a_s;
      buf_b[fill_bank_q][col_cnt_q[CW-1:0]] <= din_b_s;
    end
  end

  assign top_half = (idx_q < COLS);
  assign col_idx  = top_half ? idx_q : (idx_q - COLS);
  assign rd_bank  = ~fill_bank_q;

  always_comb begin
    wr.wr_valid = 1'b0;
    wr.wr_addr  = 12'h000;
    wr.wr_data  = 4'h0;
    if (state_q == S_DUMP) begin
      wr.wr_valid = 1'b1;
      wr.wr_addr  = {~top_half, row_q, col_idx[5:0]};
      wr.wr_data  = top_half ? buf_a[rd_bank][col_idx[CW-1:0]]
                             : buf_b[rd_bank][col_idx[CW-1:0]];
    end
  end

  assign frame_done  = (state_q == S_DONE) && (row_q == ROW_LAST);
  assign line_err    = line_err_q;
  assign overrun_err = overrun_err_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/hub75_rx.md
HUB75_RX -- requirements
Module: hub75_rx

Interface
REQ-001 SHALL have parameter COLUMNS, default 64, pixels shifted per row.
REQ-002 SHALL have parameter ROWS, default 32, scan rows per half-panel.
REQ-003 SHALL have port clk  input  1  sampling clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port pclk  input  1  panel shift clock, asynchronous to clk.
REQ-006 SHALL have port latch  input  1  panel latch, asynchronous to clk.
REQ-007 SHALL have port row_addr  input  5  panel row address.
REQ-008 SHALL have port din_a  input  4  top-half pixel data.
REQ-009 SHALL have port din_b  input  4  bottom-half pixel data.
REQ-010 SHALL have port wr_valid  output  1  capture-write request.
REQ-011 SHALL have port wr_ready  input  1  capture sink accepts the write.
REQ-012 SHALL have port wr_addr  output  12  write address {half,row[4:0],col[5:0]}.
REQ-013 SHALL have port wr_data  output  4  pixel value.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse after the last row of a frame is dumped.
REQ-015 SHALL have port line_err  output  1  sticky: latch seen with column count not equal to COLUMNS.
REQ-016 SHALL have port overrun_err  output  1  sticky: latch seen while a dump is in progress.
REQ-017 SHALL have port err_clr  input  1  synchronous clear of both sticky errors.

Function
REQ-018 SHALL pass pclk, latch, row_addr, din_a and din_b through an identical two-flop delay so that data stays aligned with the edges; edge detection SHALL use the second stage and its previous value.
REQ-019 SHALL rely on the input constraint that pclk and latch are high and low for at least 2 clk cycles each, and that data is stable from 2 clk before to 2 clk after each pclk rise.
REQ-020 On each synchronized pclk rising edge, SHALL store din_a/din_b at column col_cnt of the fill bank and increment col_cnt (7 bits).
REQ-021 SHALL not write the line buffer when col_cnt is at or above COLUMNS; col_cnt SHALL saturate at COLUMNS+1.
REQ-022 SHALL hold two line-buffer banks (ping-pong), each holding COLUMNS x 4 bits per half.
REQ-023 On a synchronized latch rising edge in IDLE, SHALL capture row_addr into row_q, swap banks, clear col_cnt, and enter DUMP.
REQ-024 SHALL set line_err when col_cnt is not equal to COLUMNS at a latch edge; the dump SHALL still proceed, and unfilled columns SHALL output stale bank contents.
REQ-025 SHALL implement states IDLE, DUMP and DONE. DUMP SHALL step idx through 0..2*COLUMNS-1; DONE SHALL return to IDLE after one cycle.
REQ-026 In DUMP, SHALL drive wr_valid=1, wr_addr={idx[6],row_q,idx[5:0]}, and wr_data equal to the top bank when idx<COLUMNS, else the bottom bank; it SHALL issue top half columns 0..63 first, then the bottom half.
REQ-027 wr_addr and wr_data SHALL be stable while wr_valid=1 and wr_ready=0; idx SHALL advance only when wr_valid and wr_ready are both high.
REQ-028 The first wr_valid SHALL assert in the clk cycle after the synchronized latch edge is detected.
REQ-029 After the final accepted write (idx=2*COLUMNS-1), SHALL deassert wr_valid and enter DONE; DONE SHALL pulse frame_done if row_q equals ROWS-1.
REQ-030 pclk edges during DUMP or DONE SHALL fill the other bank normally.
REQ-031 A latch edge during DUMP or DONE SHALL set overrun_err, clear col_cnt, and be otherwise ignored: no bank swap, no new dump, and the current dump continues.
REQ-032 If err_clr and an error event occur in the same cycle, the set SHALL win.

Reset
REQ-033 On rst: state=IDLE, wr_valid=0, wr_addr=0, wr_data=0, frame_done=0, line_err=0, overrun_err=0, col_cnt=0, fill bank=0, synchronizers=0.
REQ-034 Reset asserted mid-dump SHALL abort immediately with no further writes; line-buffer contents need not be cleared.

Verification
REQ-035 64 pclk pulses with din_a=col[3:0], din_b=~col[3:0], then latch with row_addr=5, wr_ready=1 -> 128 writes: addr 0x140..0x17F with data col[3:0], then 0x940..0x97F with data ~col[3:0], no errors.
REQ-036 Same stimulus with wr_ready toggling every other cycle -> identical write sequence, and addr/data held while ready=0.
REQ-037 63 pclk pulses then latch -> line_err=1 and a 128-write dump; err_clr -> line_err=0.
REQ-038 A second latch 10 clk after the first, with wr_ready=0 -> overrun_err=1 and exactly 128 writes total once ready is released.
REQ-039 Full line with row_addr=31 -> frame_done high exactly one cycle after the 128th accepted write; row_addr=30 -> no pulse.
REQ-040 rst asserted after 20 accepted writes -> wr_valid=0 on the next clk and all outputs at reset values.
